// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [31:0] instr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    localparam instr_t INSTR_NOP = 32'h0000_0000;
    localparam addr_t  PC_STEP   = 16'd4;

    function automatic addr_t align_word(input addr_t a);
        return {a[15:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; head is read combinationally, flush empties it.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_data,
    output fetch_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] CAP = DEPTH[AW:0];

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CAP);
    assign do_pop  = pop & ~empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front-end: sequential PC generation, credit-limited memory requests,
// in-order response buffering and redirect handling with stale-response dropping.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter int    MAX_OUT  = 2,
    parameter addr_t RESET_PC = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        ReqValid,
    input  logic        ReqReady,
    output logic [15:0] ReqAddr,
    input  logic        RspValid,
    input  logic [31:0] RspData,
    output logic        IfValid,
    input  logic        IfReady,
    output logic [31:0] IfInstr,
    output logic [15:0] IfPC,
    input  logic        Redirect,
    input  logic [15:0] RedirectPC
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE = 1;

    addr_t          fetch_pc;
    addr_t          rsp_pc;
    logic [CW-1:0]  out_cnt;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    pending;
    logic           fifo_empty;
    logic           fifo_full;
    logic           rst_hold;
    logic           req_fire;
    logic           rsp_fire;
    logic           push;
    logic           pop;
    fetch_entry_t   head;
    fetch_entry_t   rsp_entry;

    // Slots already promised: buffered entries plus live (non-dropped) requests in flight.
    assign pending  = {1'b0, fifo_count} + {1'b0, out_cnt} - {1'b0, drop_cnt};
    assign ReqValid = ~Reset & ~Redirect & ~rst_hold
                    & (out_cnt < CW'(MAX_OUT))
                    & (pending < (CW + 1)'(DEPTH));
    assign ReqAddr  = fetch_pc;
    assign req_fire = ReqValid & ReqReady;

    assign rsp_fire  = RspValid & ~Reset & (out_cnt != '0);
    assign push      = rsp_fire & (drop_cnt == '0) & ~Redirect;
    assign rsp_entry = '{pc: rsp_pc, instr: RspData};

    assign IfValid = ~fifo_empty & ~Reset;
    assign pop     = IfValid & IfReady & ~Redirect;
    assign IfInstr = IfValid ? head.instr : INSTR_NOP;
    assign IfPC    = IfValid ? head.pc : '0;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (Clock),
        .reset   (Reset),
        .push    (push),
        .pop     (pop),
        .flush   (Redirect),
        .wr_data (rsp_entry),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // A redirect converts every request still in flight into one to be dropped.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            unique case ({req_fire, rsp_fire})
                2'b10:   out_cnt <= out_cnt + ONE;
                2'b01:   out_cnt <= out_cnt - ONE;
                default: out_cnt <= out_cnt;
            endcase
            if (Redirect) begin
                fetch_pc <= align_word(RedirectPC);
                rsp_pc   <= align_word(RedirectPC);
                drop_cnt <= out_cnt - (rsp_fire ? ONE : '0);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - ONE;
                end
            end
        end
    end

    rsp_needs_request: assert property (@(posedge Clock) disable iff (Reset)
        RspValid |-> (out_cnt != '0));

    push_has_room: assert property (@(posedge Clock) disable iff (Reset)
        push |-> (~fifo_full | pop));

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch front-end between instruction memory and the decode stage of PROCESSOR.
- Generates sequential 16-bit byte addresses and issues requests over a valid/ready handshake.
- Buffers in-order 32-bit responses in a small prefetch FIFO and presents {PC, instruction} to decode.
- Supports a redirect (branch/jump): the pipeline is flushed and stale in-flight responses are discarded.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2).
- MAX_OUT, 2, maximum outstanding memory requests (1..DEPTH).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  out  1  fetch request valid.
- ReqReady  in  1  memory accepts the request this cycle.
- ReqAddr  out  16  byte address of the request, always word aligned.
- RspValid  in  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
- RspData  in  32  instruction word.
- IfValid  out  1  FIFO head valid to decode.
- IfReady  in  1  decode consumes the head.
- IfInstr  out  32  head instruction; 0 when IfValid=0.
- IfPC  out  16  head instruction address; 0 when IfValid=0.
- Redirect  in  1  flush and restart fetch.
- RedirectPC  in  16  new fetch address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset, taken at a clock edge while Reset=1, overrides everything, including a redirect in the same cycle:
  - fetch PC=RESET_PC, response PC=RESET_PC.
  - FIFO empty; outstanding count O=0; drop count D=0.
  - Outputs: ReqValid=0, IfValid=0, IfInstr=0, IfPC=0 during and in the cycle after reset.
  - Any responses arriving during reset are ignored.
- Issue rule: ReqValid = ~Reset & ~Redirect & (O < MAX_OUT) & (fifo_count + (O - D) < DEPTH). ReqAddr = fetch PC.
- req_fire = ReqValid & ReqReady:
  - fetch PC += 4, wrapping 16'hFFFC -> 16'h0000.
  - O increments.
- rsp_fire = RspValid (always accepted; the credit rule guarantees space):
  - O decrements.
  - If D > 0: the data is dropped and D decrements.
  - Otherwise {response PC, RspData} is pushed and response PC += 4 (same wrap).
- req_fire and rsp_fire in the same cycle: O is unchanged.
- Pop: pop_fire = IfValid & IfReady. Simultaneous push and pop are allowed at any occupancy. Push on empty is visible the next cycle; there is no bypass.
- Latency: request accepted at cycle N, response at N+k, IfValid at N+k+1.
- Redirect=1 (not in reset):
  - FIFO flushed; a pop in the same cycle is ignored; a non-dropped response in the same cycle is discarded.
  - D_next = O - rsp_fire, so all in-flight responses are dropped.
  - fetch PC and response PC = {RedirectPC[15:2], 2'b00}.
  - ReqValid=0 that cycle; earliest new request is the next cycle.
- Back-to-back redirects: each one recomputes D from the current O, and the last one wins.
- A response arriving with O=0 is a protocol error: it is flagged by an assertion and ignored.
- Full FIFO with IfReady=0: ReqValid=0 until space frees.
- Decode stalls never drop or duplicate instructions.

Decomposition:
- Package fetch_pkg:
  - typedef addr_t = logic [15:0]; instr_t = logic [31:0].
  - struct fetch_entry_t = {addr_t pc; instr_t instr}.
  - constant INSTR_NOP = 32'h00000000; constant PC_STEP = 4.
- Sub-module fetch_fifo (synchronous FIFO of fetch_entry_t):
  - Parameters: DEPTH.
  - Ports: push, pop, flush, data in/out, count, empty, full.
- Top level holds the PCs, the O/D counters, the issue rule and the redirect logic.

Test Plan:
- Reset, memory with ReqReady=1 and 1-cycle latency returning 32'h3C011234, 32'h34215678, 32'h00000000, IfReady=1 → ReqAddr sequence 0,4,8,…; IfPC/IfInstr = 0/3C011234, 4/34215678, 8/00000000 on consecutive cycles; first IfValid 2 cycles after the first req_fire.
- IfReady=0 for 20 cycles → exactly DEPTH=4 entries accepted, then ReqValid=0. Release IfReady → PCs 0,4,8,12,16 delivered in order, none lost or duplicated.
- Redirect to 16'h0102 with 2 requests outstanding (3-cycle memory latency) → both stale responses dropped, FIFO empties, next ReqAddr=16'h0100, first IfPC=16'h0100.
- Redirect to 16'hFFF8 → fetch addresses FFF8, FFFC, 0000, 0004 (wrap); IfPC follows the same sequence.
- Reset asserted mid-stream with 2 outstanding and a simultaneous Redirect → next cycle IfValid=0, ReqValid=0; after release, the first ReqAddr=RESET_PC.
- ReqReady toggling 1,0,1,0 with random latency 1–3 → O never exceeds MAX_OUT=2; instruction/PC stream matches the memory model.
